i2s_tx: RTL and testbench

- I2S transmitter for the DAC side of the audio path. Takes filtered 16-bit samples from the FIR/IIR output through a valid/ready handshake and serialises them onto dacdat.
- Runs in the codec's bclk domain, and the codec is the clock master: bclk and lrclk are both inputs.
- Mono path: the same sample is sent in the left and right slots of each frame.

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_lr_edge.sv | 20 ++
 rtl/i2s_tx.sv | 132 +++++++++++++
 tb/tb_i2s_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the transmitter and the receiver.
package i2s_pkg;

  localparam int I2S_DATA_W     = 16;
  localparam int I2S_DELAY_BITS = 1;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    LEFT       = 2'd1,
    RIGHT      = 2'd2
  } i2s_state_e;

endpackage

// File: rtl/i2s_lr_edge.sv
// lrclk edge detector in the bclk falling-edge domain.
module i2s_lr_edge (
  input  logic i_bclk,
  input  logic i_rst_n,
  input  logic i_lrclk,
  output logic o_lr_fall,
  output logic o_lr_rise
);

  logic r_lrclk_d;

  always_ff @(negedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) r_lrclk_d <= 1'b0;
    else          r_lrclk_d <= i_lrclk;
  end

  assign o_lr_fall = !i_lrclk && r_lrclk_d;
  assign o_lr_rise = i_lrclk && !r_lrclk_d;

endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: one-entry sample buffer, same word sent in both slots.
// Define I2S_TX_UNDERRUN_CNT_EN to add a saturating 8-bit underrun counter port.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int CNT_W  = 5
) (
  input  logic              bclk,
  input  logic              rst_n,
  input  logic              lrclk,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              dacdat,
  output logic              underrun,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic [7:0]        underrun_cnt,
`endif
  output logic [1:0]        o_dbg_state
);

  // Handshake: a sample moves into the buffer on the negedge where
  // sample_valid && sample_ready; sample_ready depends only on buffer state.

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(I2S_DELAY_BITS);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(I2S_DELAY_BITS + DATA_W - 1);

  logic              w_lr_fall;
  logic              w_lr_rise;
  logic              w_push;
  logic              w_load;
  logic              w_in_data;
  logic [CNT_W-1:0]  w_cnt_next;

  logic              r_buf_full;
  logic [DATA_W-1:0] r_buf;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_frame_word;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_dacdat;
  logic              r_underrun;
  i2s_state_e        r_state;

  i2s_lr_edge u_lr_edge (
    .i_bclk    (bclk),
    .i_rst_n   (rst_n),
    .i_lrclk   (lrclk),
    .o_lr_fall (w_lr_fall),
    .o_lr_rise (w_lr_rise)
  );

  assign w_push     = sample_valid && !r_buf_full;
  assign w_load     = w_lr_fall && (r_state != LEFT);
  assign w_cnt_next = (w_lr_fall || w_lr_rise) ? '0 :
                      (r_bit_cnt == CNT_MAX)   ? CNT_MAX :
                                                 r_bit_cnt + 1'b1;
  // Count 0 is the one-bit I2S delay; data follows, then zero padding.
  assign w_in_data  = (w_cnt_next >= DATA_FIRST) && (w_cnt_next <= DATA_LAST);

  always_ff @(negedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full   <= 1'b0;
      r_buf        <= '0;
      r_shift      <= '0;
      r_frame_word <= '0;
      r_bit_cnt    <= '0;
      r_dacdat     <= 1'b0;
      r_underrun   <= 1'b0;
      r_state      <= WAIT_FRAME;
    end else begin
      r_bit_cnt  <= w_cnt_next;
      r_underrun <= 1'b0;

      // Buffer is freed by a frame load, but a new sample only enters
      // when it was already empty before this edge.
      if (w_push) begin
        r_buf      <= sample_in;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end

      if (w_load) begin
        r_state  <= LEFT;
        r_dacdat <= 1'b0;
        if (r_buf_full) begin
          r_shift      <= r_buf;
          r_frame_word <= r_buf;
        end else begin
          r_shift      <= '0;
          r_frame_word <= '0;
          r_underrun   <= 1'b1;
        end
      end else if (w_lr_rise && (r_state == LEFT)) begin
        r_state  <= RIGHT;
        r_shift  <= r_frame_word;
        r_dacdat <= 1'b0;
      end else if ((r_state == LEFT) || (r_state == RIGHT)) begin
        if (w_in_data) begin
          r_dacdat <= r_shift[DATA_W-1];
          r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
        end else begin
          r_dacdat <= 1'b0;
        end
      end else begin
        r_state  <= WAIT_FRAME;
        r_dacdat <= 1'b0;
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0] r_underrun_cnt;

  always_ff @(negedge bclk or negedge rst_n) begin
    if (!rst_n)
      r_underrun_cnt <= 8'd0;
    else if (w_load && !r_buf_full && (r_underrun_cnt != 8'hFF))
      r_underrun_cnt <= r_underrun_cnt + 8'd1;
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  assign sample_ready = !r_buf_full;
  assign dacdat       = r_dacdat;
  assign underrun     = r_underrun;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: slot-level reference model of the serial stream and buffer.
module tb_i2s_tx;

  localparam int DW = 16;

  logic          bclk = 1'b0;
  logic          rst_n = 1'b1;
  logic          lrclk = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_ready;
  logic          dacdat;
  logic          underrun;
  logic [1:0]    dbg_state;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0]    underrun_cnt;
`endif

  i2s_tx dut (
    .bclk         (bclk),
    .rst_n        (rst_n),
    .lrclk        (lrclk),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dacdat       (dacdat),
    .underrun     (underrun),
`ifdef I2S_TX_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 bclk = ~bclk;

  int n_cmp = 0;
  int n_bad = 0;

  // scoreboard: {sample_ready, underrun, dacdat} expected after each negedge
  logic [2:0]    exp_q[$];
  logic [DW-1:0] pend_q[$];
  logic          m_lr;
  logic [DW-1:0] m_word;
  int            m_idx;
  int            m_ucnt;

  task automatic model_reset();
    exp_q.delete();
    pend_q.delete();
    m_lr   = 1'b0;
    m_word = '0;
    m_idx  = 100;
    m_ucnt = 0;
  endtask

  // Check what the previous negedge produced, then drive the next bclk.
  task automatic apply(input logic lr, input logic v, input logic [DW-1:0] d);
    logic [2:0] e;
    logic       fall;
    logic       rise;
    logic       ready_pre;
    logic       und;
    logic       dac;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({sample_ready, underrun, dacdat} !== e) begin
        n_bad++;
        $display("FAIL stream t=%0t {ready,underrun,dacdat} got %b want %b",
                 $time, {sample_ready, underrun, dacdat}, e);
      end
    end
    fall      = m_lr && !lr;
    rise      = !m_lr && lr;
    ready_pre = (pend_q.size() == 0);
    und       = 1'b0;
    if (fall) begin
      m_idx = 0;
      if (!ready_pre) begin
        m_word = pend_q.pop_front();
      end else begin
        m_word = '0;
        und    = 1'b1;
        if (m_ucnt < 255) m_ucnt++;
      end
    end else if (rise) begin
      m_idx = 0;
    end else if (m_idx < 1000) begin
      m_idx++;
    end
    dac = 1'b0;
    if (m_idx >= 1 && m_idx <= DW) dac = m_word[DW - m_idx];
    if (v && ready_pre) pend_q.push_back(d);
    exp_q.push_back({(pend_q.size() == 0), und, dac});
    lrclk        = lr;
    sample_valid = v;
    sample_in    = d;
    m_lr         = lr;
  endtask

  task automatic step(input logic lr, input logic v, input logic [DW-1:0] d);
    @(posedge bclk);
    apply(lr, v, d);
  endtask

  task automatic slot(input logic lr, input int len, input int feed_at,
                      input logic [DW-1:0] feed_d, input bit rnd);
    for (int i = 0; i < len; i++) begin
      logic          v;
      logic [DW-1:0] d;
      v = 1'b0;
      d = DW'($urandom);
      if (i == feed_at) begin
        v = 1'b1;
        d = feed_d;
      end else if (rnd) begin
        v = ($urandom_range(0, 3) == 0);
      end
      step(lr, v, d);
    end
  endtask

  task automatic do_reset(input logic lr);
    #2 rst_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    n_cmp += 4;
    if (dacdat !== 1'b0) begin n_bad++; $display("FAIL rst_dacdat got %b want 0", dacdat); end
    if (underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun got %b want 0", underrun); end
    if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", sample_ready); end
    if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_state got %0d want 0", dbg_state); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    n_cmp++;
    if (underrun_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_ucnt got %0d want 0", underrun_cnt); end
`endif
    model_reset();
    @(posedge bclk);
    rst_n = 1'b1;
    apply(lr, 1'b0, '0);
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    do_reset(1'b0);
  endtask

  task automatic test_basic();
    slot(1'b1, 4, 0, 16'hA5C3, 1'b0);
    slot(1'b0, 32, -1, '0, 1'b0);
    slot(1'b1, 32, -1, '0, 1'b0);
    n_cmp++;
    if (dbg_state !== 2'd2) begin n_bad++; $display("FAIL basic_state got %0d want 2", dbg_state); end
  endtask

  task automatic test_underrun();
    slot(1'b0, 32, -1, '0, 1'b0);
    slot(1'b1, 32, -1, '0, 1'b0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    n_cmp++;
    if (underrun_cnt !== 8'(m_ucnt)) begin n_bad++; $display("FAIL ucnt_one got %0d want %0d", underrun_cnt, m_ucnt); end
    for (int f = 0; f < 300; f++) begin
      slot(1'b0, 2, -1, '0, 1'b0);
      slot(1'b1, 2, -1, '0, 1'b0);
    end
    n_cmp++;
    if (underrun_cnt !== 8'd255) begin n_bad++; $display("FAIL ucnt_sat got %0d want 255", underrun_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    step(1'b1, 1'b1, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 16'h5678);
      n_cmp++;
      if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold got %b want 0", sample_ready); end
    end
    step(1'b0, 1'b1, 16'h5678);
    n_cmp++;
    if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL bp_at_fall got %b want 0", sample_ready); end
    step(1'b0, 1'b1, 16'h5678);
    n_cmp++;
    if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL bp_freed got %b want 1", sample_ready); end
    step(1'b0, 1'b0, '0);
    n_cmp++;
    if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL bp_taken got %b want 0", sample_ready); end
    slot(1'b0, 29, -1, '0, 1'b0);
    slot(1'b1, 32, -1, '0, 1'b0);
    slot(1'b0, 32, -1, '0, 1'b0);
    slot(1'b1, 32, -1, '0, 1'b0);
  endtask

  task automatic test_short_slot();
    slot(1'b0, 10, -1, '0, 1'b0);
    slot(1'b1, 10, 2, 16'hFFFF, 1'b0);
    for (int f = 0; f < 3; f++) begin
      slot(1'b0, 10, 5, 16'hFFFF, 1'b0);
      slot(1'b1, 10, -1, '0, 1'b0);
    end
  endtask

  task automatic test_long_slot();
    slot(1'b1, 4, 0, DW'($urandom), 1'b0);
    slot(1'b0, 45, -1, '0, 1'b0);
    slot(1'b1, 45, -1, '0, 1'b0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      slot(1'b0, $urandom_range(17, 40), -1, '0, 1'b1);
      slot(1'b1, $urandom_range(17, 40), -1, '0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    slot(1'b1, 4, 0, DW'($urandom), 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i == 2) step(1'b0, 1'b1, DW'($urandom));
      else        step(1'b0, 1'b0, '0);
    end
    do_reset(1'b0);
    slot(1'b0, 20, -1, '0, 1'b0);
    slot(1'b1, 16, 3, DW'($urandom), 1'b0);
    slot(1'b0, 32, -1, '0, 1'b0);
    slot(1'b1, 32, -1, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_backpressure();
    test_short_slot();
    test_long_slot();
    test_random();
    test_reset_mid();
    step(lrclk, 1'b0, '0);
    if (exp_q.size() != 1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_depth got %0d want 1", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
